// File: rtl/uart_rx_ctrl.sv
// rtl/uart_rx_ctrl.sv - UART receiver with oversampled start/data/parity/stop framing and error pulses
module uart_rx_ctrl #(
    parameter int DATA_W     = 8,
    parameter int PRESCALE_W = 6
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  RX_IN,
    input  logic [PRESCALE_W-1:0] Prescale,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic                  STOP2,
    output logic [DATA_W-1:0]     P_DATA,
    output logic                  data_valid,
    output logic                  par_err,
    output logic                  stp_err,
    output logic                  busy
);
    typedef enum logic [2:0] {
        IDLE   = 3'b000,
        START  = 3'b001,
        DATA   = 3'b011,
        PARITY = 3'b010,
        STOP   = 3'b110,
        VALID  = 3'b111
    } state_t;

    state_t                state;
    logic [PRESCALE_W-1:0] cnt;
    logic [PRESCALE_W-1:0] p_q;
    logic [3:0]            bit_idx;
    logic                  stop_idx;
    logic [DATA_W-1:0]     shift_q;
    logic                  par_en_q;
    logic                  par_typ_q;
    logic                  stop2_q;
    logic [2:0]            smp;
    logic                  par_flag;
    logic                  stp_flag;

    logic [PRESCALE_W-1:0] presc_even;
    logic [PRESCALE_W-1:0] presc_eff;
    logic [PRESCALE_W-1:0] half;
    logic [PRESCALE_W-1:0] last_edge;
    logic                  bit_end;
    logic                  bit_val;
    logic                  exp_par;

    // Odd prescales would put the centre sample off-bit; tiny ones leave no room for three samples.
    assign presc_even = Prescale & ~PRESCALE_W'(1);
    assign presc_eff  = (presc_even < PRESCALE_W'(8)) ? PRESCALE_W'(8) : presc_even;
    assign half       = p_q >> 1;
    assign last_edge  = p_q - PRESCALE_W'(1);
    assign bit_end    = (cnt == last_edge);
    assign bit_val    = (smp[0] & smp[1]) | (smp[0] & smp[2]) | (smp[1] & smp[2]);
    assign exp_par    = (^shift_q) ^ par_typ_q;
    assign busy       = (state != IDLE);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state      <= IDLE;
            cnt        <= '0;
            p_q        <= '0;
            bit_idx    <= '0;
            stop_idx   <= 1'b0;
            shift_q    <= '0;
            par_en_q   <= 1'b0;
            par_typ_q  <= 1'b0;
            stop2_q    <= 1'b0;
            smp        <= '0;
            par_flag   <= 1'b0;
            stp_flag   <= 1'b0;
            P_DATA     <= '0;
            data_valid <= 1'b0;
            par_err    <= 1'b0;
            stp_err    <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            par_err    <= 1'b0;
            stp_err    <= 1'b0;

            if (state != IDLE && state != VALID) begin
                if (cnt == half - PRESCALE_W'(1)) smp[0] <= RX_IN;
                if (cnt == half)                  smp[1] <= RX_IN;
                if (cnt == half + PRESCALE_W'(1)) smp[2] <= RX_IN;
                cnt <= bit_end ? '0 : cnt + PRESCALE_W'(1);
            end

            case (state)
                IDLE, VALID: begin
                    // A start edge right after VALID is taken immediately so back-to-back frames survive.
                    if (!RX_IN) begin
                        state     <= START;
                        cnt       <= '0;
                        p_q       <= presc_eff;
                        par_en_q  <= PAR_EN;
                        par_typ_q <= PAR_TYP;
                        stop2_q   <= STOP2;
                        bit_idx   <= '0;
                        stop_idx  <= 1'b0;
                        par_flag  <= 1'b0;
                        stp_flag  <= 1'b0;
                    end else begin
                        state <= IDLE;
                    end
                end
                START: begin
                    if (bit_end) state <= bit_val ? IDLE : DATA;
                end
                DATA: begin
                    if (bit_end) begin
                        shift_q <= {bit_val, shift_q[DATA_W-1:1]};
                        bit_idx <= bit_idx + 4'd1;
                        if (bit_idx == 4'(DATA_W - 1)) state <= par_en_q ? PARITY : STOP;
                    end
                end
                PARITY: begin
                    if (bit_end) begin
                        par_flag <= (bit_val != exp_par);
                        state    <= STOP;
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        if (stop2_q && !stop_idx) begin
                            stop_idx <= 1'b1;
                            if (!bit_val) stp_flag <= 1'b1;
                        end else if (par_flag || stp_flag || !bit_val) begin
                            par_err <= par_flag;
                            stp_err <= stp_flag | ~bit_val;
                            state   <= IDLE;
                        end else begin
                            P_DATA     <= shift_q;
                            data_valid <= 1'b1;
                            state      <= VALID;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb/tb_uart_rx_ctrl.sv - scoreboard bench for uart_rx_ctrl against a frame-level reference model
module tb_uart_rx_ctrl;
    localparam int DATA_W     = 8;
    localparam int PRESCALE_W = 6;

    logic                  CLK      = 1'b0;
    logic                  RST      = 1'b0;
    logic                  RX_IN    = 1'b1;
    logic [PRESCALE_W-1:0] Prescale = 6'd8;
    logic                  PAR_EN   = 1'b0;
    logic                  PAR_TYP  = 1'b0;
    logic                  STOP2    = 1'b0;
    logic [DATA_W-1:0]     P_DATA;
    logic                  data_valid;
    logic                  par_err;
    logic                  stp_err;
    logic                  busy;

    uart_rx_ctrl #(.DATA_W(DATA_W), .PRESCALE_W(PRESCALE_W)) dut (
        .CLK(CLK), .RST(RST), .RX_IN(RX_IN), .Prescale(Prescale),
        .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .STOP2(STOP2),
        .P_DATA(P_DATA), .data_valid(data_valid), .par_err(par_err),
        .stp_err(stp_err), .busy(busy)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct {
        int                cyc;
        bit                dv;
        bit                pe;
        bit                se;
        logic [DATA_W-1:0] data;
    } exp_t;

    exp_t              exp_q[$];
    int                checks    = 0;
    int                errors    = 0;
    logic [DATA_W-1:0] last_good = '0;
    int                ready     = 0;   // first edge at which the receiver can see a new start bit

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, req, cyc);
        end
    endtask

    always @(negedge CLK) begin : monitor
        exp_t e;
        if (RST && (data_valid || par_err || stp_err)) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pulse: got dv=%0b pe=%0b se=%0b expected none at cycle %0d",
                         data_valid, par_err, stp_err, cyc);
            end else begin
                e = exp_q.pop_front();
                check("out_cycle", cyc, e.cyc);
                check("data_valid", data_valid, e.dv);
                check("par_err", par_err, e.pe);
                check("stp_err", stp_err, e.se);
                if (e.dv) begin
                    check("p_data", P_DATA, e.data);
                    last_good = e.data;
                end else begin
                    check("p_data_hold", P_DATA, last_good);
                end
            end
        end else if (exp_q.size() != 0 && exp_q[0].cyc < cyc) begin
            e = exp_q.pop_front();
            checks++;
            errors++;
            $display("FAIL missing_output: got nothing expected pulse at cycle %0d", e.cyc);
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle(input int n);
        RX_IN = 1'b1;
        repeat (n) tick();
    endtask

    function automatic int eff_p(input int raw);
        int p;
        p = raw & ~1;
        return (p < 8) ? 8 : p;
    endfunction

    // Keep the receiver's start detection at most one cycle behind the line.
    task automatic wait_ready(output int s);
        s = cyc + 1;
        while (ready > s + 1) begin
            RX_IN = 1'b1;
            tick();
            s = cyc + 1;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_p_data"}, P_DATA, 0);
        check({tag, "_data_valid"}, data_valid, 0);
        check({tag, "_par_err"}, par_err, 0);
        check({tag, "_stp_err"}, stp_err, 0);
        check({tag, "_busy"}, busy, 0);
    endtask

    task automatic send_frame(input logic [DATA_W-1:0] data, input int raw_p,
                              input bit pe_en, input bit typ, input bit st2, input bit flip_par,
                              input bit [1:0] stop_bad, input bit brk, input bit flip_mid,
                              input bit abort);
        int                s;
        int                detect;
        int                p;
        int                n;
        int                flipk;
        bit                bits [13];
        logic [DATA_W-1:0] rx_data;
        bit                pe;
        bit                se;

        Prescale = PRESCALE_W'(raw_p);
        PAR_EN   = pe_en;
        PAR_TYP  = typ;
        STOP2    = st2;
        p = eff_p(raw_p);
        n = 2 + DATA_W + int'(pe_en) + int'(st2);

        for (int i = 0; i < 13; i++) bits[i] = 1'b1;
        bits[0] = 1'b0;
        for (int i = 0; i < DATA_W; i++) bits[1 + i] = data[i];
        if (pe_en) bits[1 + DATA_W] = (^data) ^ typ ^ flip_par;
        for (int i = 0; i <= int'(st2); i++) bits[n - 1 - int'(st2) + i] = !stop_bad[i];
        if (brk) for (int i = 0; i < n; i++) bits[i] = 1'b0;

        // Reference outcome from what the line actually carries.
        for (int i = 0; i < DATA_W; i++) rx_data[i] = bits[1 + i];
        pe = pe_en && (bits[1 + DATA_W] != ((^rx_data) ^ typ));
        se = 1'b0;
        for (int i = n - 1 - int'(st2); i < n; i++) if (!bits[i]) se = 1'b1;

        wait_ready(s);
        detect = (ready > s) ? ready : s;
        if (!abort) exp_q.push_back('{detect + n * p, !(pe || se), pe, se, rx_data});
        ready = detect + n * p + 1;
        flipk = 1 + $urandom_range(0, DATA_W - 1);

        for (int k = 0; k < n; k++) begin
            for (int c = 0; c < p; c++) begin
                RX_IN = bits[k] ^ (flip_mid && k == flipk && c == p / 2 + 1);
                if (k == 0 && c == p / 2) check("busy_in_frame", busy, 1);
                if (k == 1 && c == 0) begin
                    Prescale = PRESCALE_W'($urandom);
                    PAR_EN   = 1'($urandom);
                    PAR_TYP  = 1'($urandom);
                    STOP2    = 1'($urandom);
                end
                if (abort && k == 3 && c == 2) begin
                    check("busy_before_reset", busy, 1);
                    RX_IN     = 1'b1;
                    RST       = 1'b0;
                    last_good = '0;
                    #2;
                    check_reset_outputs("async_reset");
                    tick();
                    tick();
                    check_reset_outputs("held_reset");
                    RST   = 1'b1;
                    ready = cyc + 1;
                    return;
                end
                tick();
            end
        end
    endtask

    task automatic glitch(input int raw_p);
        int s;
        int detect;
        int p;
        Prescale = PRESCALE_W'(raw_p);
        p = eff_p(raw_p);
        wait_ready(s);
        detect = (ready > s) ? ready : s;
        ready  = detect + p + 1;
        RX_IN = 1'b0;
        tick();
        tick();
        RX_IN = 1'b1;
        tick();
        check("busy_glitch_start", busy, 1);
        while (cyc < detect + p) tick();
        check("busy_glitch_end", busy, 0);
    endtask

    initial begin
        RST = 1'b0;
        repeat (3) tick();
        check_reset_outputs("reset");
        RST   = 1'b1;
        ready = cyc + 1;
        idle(2);

        send_frame(8'hA5, 8, 1, 0, 0, 0, 2'b00, 0, 0, 0);
        idle(4);
        send_frame(8'hA5, 8, 1, 0, 0, 1, 2'b00, 0, 0, 0);
        idle(4);
        send_frame(8'hA5, 8, 1, 0, 1, 0, 2'b10, 0, 0, 0);
        idle(4);
        glitch(8);
        idle(4);
        send_frame(8'h3C, 8, 0, 0, 0, 0, 2'b00, 0, 0, 0);
        send_frame(8'hC3, 8, 0, 0, 0, 0, 2'b00, 0, 0, 0);
        idle(4);
        send_frame(8'h00, 8, 1, 0, 0, 0, 2'b00, 1, 0, 0);
        send_frame(8'h96, 8, 1, 1, 0, 0, 2'b00, 0, 1, 0);
        idle(4);
        send_frame(8'h77, 8, 0, 0, 0, 0, 2'b00, 0, 0, 1);
        send_frame(8'h5A, 8, 0, 0, 0, 0, 2'b00, 0, 0, 0);
        idle(4);

        for (int f = 0; f < 40; f++) begin
            int raw;
            raw = $urandom_range(0, 21);
            if ($urandom_range(0, 9) == 0) begin
                glitch(raw);
            end else begin
                send_frame(DATA_W'($urandom), raw, 1'($urandom), 1'($urandom), 1'($urandom),
                           $urandom_range(0, 4) == 0,
                           {$urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0},
                           $urandom_range(0, 19) == 0, $urandom_range(0, 2) == 0, 1'b0);
            end
            idle($urandom_range(0, 2));
        end

        RX_IN = 1'b1;
        while (cyc < ready + 4) tick();
        check("queue_drained", exp_q.size(), 0);
        check("busy_final", busy, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
